// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and pointer type for the 8x16 FIFO controller.
package fifo_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 8;
   localparam int DEF_ADDR  = 3;
   typedef logic [DEF_ADDR:0] ptr_t;
endpackage

// File: rtl/sync_fifo_ctrl_8x16_if.sv
// sync_fifo_ctrl_8x16_if: producer/consumer handshake and RAM-port signals of the FIFO controller.
interface sync_fifo_ctrl_8x16_if import fifo_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ADDR  = DEF_ADDR
);
   logic             wr_en, rd_en, ram_we, ram_re, data_valid, full, empty, overflow, underflow;
   logic [WIDTH-1:0] data_in, ram_data_in, ram_data_out, data_out;
   logic [ADDR-1:0]  ram_wr_addr, ram_rd_addr;
   logic [ADDR:0]    count;
   modport master (
      output wr_en, data_in, rd_en, ram_data_out,
      input  ram_we, ram_wr_addr, ram_data_in, ram_re, ram_rd_addr,
      input  data_out, data_valid, full, empty, count, overflow, underflow
   );
   modport slave (
      input  wr_en, data_in, rd_en, ram_data_out,
      output ram_we, ram_wr_addr, ram_data_in, ram_re, ram_rd_addr,
      output data_out, data_valid, full, empty, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_ptr.sv
// fifo_ptr: lap-bit pointer counting modulo 2*DEPTH with an increment enable.
module fifo_ptr import fifo_pkg::*; #(
   parameter int DEPTH = DEF_DEPTH,
   parameter int W     = $bits(ptr_t)
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         i_inc,
   output logic [W-1:0] o_ptr
);
   logic [W-1:0] r_ptr;
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) r_ptr <= '0;
      else if (i_inc) r_ptr <= (r_ptr == W'(2*DEPTH-1)) ? '0 : r_ptr + 1'b1;
   assign o_ptr = r_ptr;
endmodule

// File: rtl/sync_fifo_ctrl_8x16.sv
// sync_fifo_ctrl_8x16: synchronous FIFO controller driving an external 8x16 RAM with 1-cycle read latency.
module sync_fifo_ctrl_8x16 import fifo_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int ADDR  = DEF_ADDR
) (
   input logic                  clk,
   input logic                  clr_n,
   sync_fifo_ctrl_8x16_if.slave bus
);
   logic [ADDR:0]    w_wptr, w_rptr, r_count;
   logic [WIDTH-1:0] w_data_out;
   logic             w_full, w_empty, w_wa, w_ra, r_valid, r_ovf, r_udf;
   fifo_ptr #(.DEPTH(DEPTH), .W(ADDR+1)) u_wptr (.clk(clk), .clr_n(clr_n), .i_inc(w_wa), .o_ptr(w_wptr));
   fifo_ptr #(.DEPTH(DEPTH), .W(ADDR+1)) u_rptr (.clk(clk), .clr_n(clr_n), .i_inc(w_ra), .o_ptr(w_rptr));
   // Flags come straight from registered pointers, so they reflect the start of the cycle.
   always_comb begin
      w_empty    = w_wptr == w_rptr;
      w_full     = (w_wptr[ADDR-1:0] == w_rptr[ADDR-1:0]) && (w_wptr[ADDR] != w_rptr[ADDR]);
      w_wa       = bus.wr_en && !w_full;
      w_ra       = bus.rd_en && !w_empty;
      w_data_out = r_valid ? bus.ram_data_out : '0;
   end
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) begin
         r_count <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         r_count <= (w_wa && !w_ra) ? r_count + 1'b1 : (w_ra && !w_wa) ? r_count - 1'b1 : r_count;
         r_valid <= w_ra;
         r_ovf   <= r_ovf | (bus.wr_en & w_full);
         r_udf   <= r_udf | (bus.rd_en & w_empty);
      end
   assign bus.ram_we      = w_wa;
   assign bus.ram_wr_addr = w_wptr[ADDR-1:0];
   assign bus.ram_data_in = bus.data_in;
   assign bus.ram_re      = w_ra;
   assign bus.ram_rd_addr = w_rptr[ADDR-1:0];
   assign bus.data_out    = w_data_out;
   assign bus.data_valid  = r_valid;
   assign bus.full        = w_full;
   assign bus.empty       = w_empty;
   assign bus.count       = r_count;
   assign bus.overflow    = r_ovf;
   assign bus.underflow   = r_udf;
endmodule

// File: tb/tb_sync_fifo_ctrl_8x16.sv
// tb_sync_fifo_ctrl_8x16: directed scenario tests of the FIFO controller with a behavioural 8x16 RAM beside it.
module tb_sync_fifo_ctrl_8x16;
   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] mem [8];
   sync_fifo_ctrl_8x16_if #(.WIDTH(16), .ADDR(3)) bus ();
   sync_fifo_ctrl_8x16 #(.WIDTH(16), .DEPTH(8), .ADDR(3)) dut (.clk(clk), .clr_n(clr_n), .bus(bus.slave));
   always #5 clk = ~clk;
   // RAM: registered read data, cleared by the same reset
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) bus.ram_data_out <= '0;
      else begin
         if (bus.ram_we) mem[bus.ram_wr_addr] <= bus.ram_data_in;
         if (bus.ram_re) bus.ram_data_out <= mem[bus.ram_rd_addr];
      end
   task automatic do_reset;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      clr_n = 1'b0;
      @(negedge clk) clr_n = 1'b1;
      @(posedge clk) #1;
   endtask
   task automatic test_reset;
      #2;
      checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
      checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.data_valid); end
      checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b%b exp 00", bus.overflow, bus.underflow); end
      checks++; if (bus.data_out !== 16'h0) begin errors++; $display("FAIL reset_data_out got %h exp 0000", bus.data_out); end
      checks++; if (bus.ram_wr_addr !== 3'd0 || bus.ram_rd_addr !== 3'd0) begin errors++; $display("FAIL reset_ptrs got %0d/%0d exp 0/0", bus.ram_wr_addr, bus.ram_rd_addr); end
      @(negedge clk) clr_n = 1'b1;
      @(posedge clk) #1;
   endtask
   task automatic test_underflow;
      do_reset();
      bus.rd_en = 1'b1;
      #1;
      checks++; if (bus.ram_re !== 1'b0) begin errors++; $display("FAIL udf_ram_re got %b exp 0", bus.ram_re); end
      @(posedge clk) #1;
      bus.rd_en = 1'b0;
      checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL udf_valid got %b exp 0", bus.data_valid); end
      checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL udf_flag got %b exp 1", bus.underflow); end
      checks++; if (bus.empty !== 1'b1 || bus.overflow !== 1'b0) begin errors++; $display("FAIL udf_state got empty=%b ovf=%b exp 1/0", bus.empty, bus.overflow); end
      @(posedge clk) #1;
      checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL udf_valid_late got %b exp 0", bus.data_valid); end
   endtask
   task automatic test_fill;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         bus.wr_en = 1'b1;
         bus.data_in = 16'(16'h1000 + i);
         #1;
         checks++; if (bus.ram_we !== 1'b1 || bus.ram_wr_addr !== 3'(i)) begin errors++; $display("FAIL fill_we[%0d] got we=%b addr=%0d exp 1/%0d", i, bus.ram_we, bus.ram_wr_addr, i); end
         checks++; if (bus.ram_data_in !== 16'(16'h1000 + i)) begin errors++; $display("FAIL fill_data[%0d] got %h exp %h", i, bus.ram_data_in, 16'(16'h1000 + i)); end
         @(posedge clk) #1;
      end
      bus.data_in = 16'h1008;
      #1;
      checks++; if (bus.full !== 1'b1 || bus.count !== 4'd8) begin errors++; $display("FAIL fill_full got full=%b count=%0d exp 1/8", bus.full, bus.count); end
      checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL fill_9th_we got %b exp 0", bus.ram_we); end
      @(posedge clk) #1;
      bus.wr_en = 1'b0;
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b exp 1", bus.overflow); end
      checks++; if (bus.count !== 4'd8 || bus.underflow !== 1'b0) begin errors++; $display("FAIL fill_after got count=%0d udf=%b exp 8/0", bus.count, bus.underflow); end
   endtask
   task automatic test_drain;
      checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL drain_idle_valid got %b exp 0", bus.data_valid); end
      for (int i = 0; i < 8; i++) begin
         bus.rd_en = 1'b1;
         #1;
         checks++; if (bus.ram_re !== 1'b1 || bus.ram_rd_addr !== 3'(i)) begin errors++; $display("FAIL drain_re[%0d] got re=%b addr=%0d exp 1/%0d", i, bus.ram_re, bus.ram_rd_addr, i); end
         @(posedge clk) #1;
         checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 16'(16'h1000 + i)) begin errors++; $display("FAIL drain_data[%0d] got v=%b %h exp 1/%h", i, bus.data_valid, bus.data_out, 16'(16'h1000 + i)); end
      end
      bus.rd_en = 1'b0;
      checks++; if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin errors++; $display("FAIL drain_empty got empty=%b count=%0d exp 1/0", bus.empty, bus.count); end
      @(posedge clk) #1;
      checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL drain_valid_off got %b exp 0", bus.data_valid); end
   endtask
   task automatic test_wrap;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         bus.wr_en = 1'b1;
         bus.data_in = 16'(16'h2000 + i);
         @(posedge clk) #1;
      end
      bus.wr_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.rd_en = 1'b1;
         @(posedge clk) #1;
         checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 16'(16'h2000 + i)) begin errors++; $display("FAIL wrap_pre[%0d] got v=%b %h exp 1/%h", i, bus.data_valid, bus.data_out, 16'(16'h2000 + i)); end
      end
      bus.rd_en = 1'b0;
      for (int k = 0; k < 12; k++) begin
         bus.wr_en = 1'b1;
         bus.data_in = 16'(16'h3000 + k);
         bus.rd_en = (k > 0);
         #1;
         checks++; if (bus.ram_we !== 1'b1 || bus.ram_wr_addr !== 3'(5 + k)) begin errors++; $display("FAIL wrap_waddr[%0d] got we=%b addr=%0d exp 1/%0d", k, bus.ram_we, bus.ram_wr_addr, 3'(5 + k)); end
         checks++; if (bus.full !== 1'b0 || bus.empty !== (k == 0)) begin errors++; $display("FAIL wrap_flags[%0d] got full=%b empty=%b exp 0/%b", k, bus.full, bus.empty, k == 0); end
         if (k > 0) begin
            checks++; if (bus.ram_re !== 1'b1 || bus.ram_rd_addr !== 3'(4 + k)) begin errors++; $display("FAIL wrap_raddr[%0d] got re=%b addr=%0d exp 1/%0d", k, bus.ram_re, bus.ram_rd_addr, 3'(4 + k)); end
         end
         @(posedge clk) #1;
         checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL wrap_count[%0d] got %0d exp 1", k, bus.count); end
         if (k > 0) begin
            checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 16'(16'h3000 + k - 1)) begin errors++; $display("FAIL wrap_data[%0d] got v=%b %h exp 1/%h", k, bus.data_valid, bus.data_out, 16'(16'h3000 + k - 1)); end
         end
      end
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b1;
      #1;
      checks++; if (bus.ram_rd_addr !== 3'd0) begin errors++; $display("FAIL wrap_last_raddr got %0d exp 0", bus.ram_rd_addr); end
      @(posedge clk) #1;
      bus.rd_en = 1'b0;
      checks++; if (bus.data_out !== 16'h300B) begin errors++; $display("FAIL wrap_last_data got %h exp 300b", bus.data_out); end
      checks++; if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin errors++; $display("FAIL wrap_end got empty=%b count=%0d exp 1/0", bus.empty, bus.count); end
      checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin errors++; $display("FAIL wrap_sticky got %b%b exp 00", bus.overflow, bus.underflow); end
   endtask
   task automatic test_back_to_back;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         bus.wr_en = 1'b1;
         bus.data_in = 16'(16'h4000 + i);
         @(posedge clk) #1;
      end
      for (int k = 0; k < 10; k++) begin
         bus.rd_en = 1'b1;
         bus.data_in = 16'(16'h4004 + k);
         #1;
         checks++; if (bus.ram_we !== 1'b1 || bus.ram_re !== 1'b1) begin errors++; $display("FAIL b2b_strobes[%0d] got we=%b re=%b exp 1/1", k, bus.ram_we, bus.ram_re); end
         @(posedge clk) #1;
         checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL b2b_count[%0d] got %0d exp 4", k, bus.count); end
         checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 16'(16'h4000 + k)) begin errors++; $display("FAIL b2b_data[%0d] got v=%b %h exp 1/%h", k, bus.data_valid, bus.data_out, 16'(16'h4000 + k)); end
      end
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask
   task automatic test_simul_edges;
      do_reset();
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      bus.data_in = 16'h5000;
      #1;
      checks++; if (bus.ram_we !== 1'b1 || bus.ram_re !== 1'b0) begin errors++; $display("FAIL edge_empty_strobes got we=%b re=%b exp 1/0", bus.ram_we, bus.ram_re); end
      @(posedge clk) #1;
      bus.rd_en = 1'b0;
      checks++; if (bus.count !== 4'd1 || bus.underflow !== 1'b1 || bus.data_valid !== 1'b0) begin errors++; $display("FAIL edge_empty_after got count=%0d udf=%b v=%b exp 1/1/0", bus.count, bus.underflow, bus.data_valid); end
      for (int i = 1; i < 8; i++) begin
         bus.data_in = 16'(16'h5000 + i);
         @(posedge clk) #1;
      end
      bus.rd_en = 1'b1;
      bus.data_in = 16'h5FFF;
      #1;
      checks++; if (bus.ram_we !== 1'b0 || bus.ram_re !== 1'b1) begin errors++; $display("FAIL edge_full_strobes got we=%b re=%b exp 0/1", bus.ram_we, bus.ram_re); end
      @(posedge clk) #1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      checks++; if (bus.count !== 4'd7 || bus.overflow !== 1'b1) begin errors++; $display("FAIL edge_full_after got count=%0d ovf=%b exp 7/1", bus.count, bus.overflow); end
      checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 16'h5000) begin errors++; $display("FAIL edge_full_data got v=%b %h exp 1/5000", bus.data_valid, bus.data_out); end
   endtask
   task automatic test_midreset;
      do_reset();
      bus.rd_en = 1'b1;
      @(posedge clk) #1;
      bus.rd_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.wr_en = 1'b1;
         bus.data_in = 16'(16'h6000 + i);
         @(posedge clk) #1;
      end
      bus.wr_en = 1'b0;
      checks++; if (bus.count !== 4'd6 || bus.underflow !== 1'b1) begin errors++; $display("FAIL mid_pre got count=%0d udf=%b exp 6/1", bus.count, bus.underflow); end
      #2 clr_n = 1'b0;
      #1;
      checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL mid_async got count=%0d empty=%b exp 0/1", bus.count, bus.empty); end
      checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin errors++; $display("FAIL mid_sticky got %b%b exp 00", bus.overflow, bus.underflow); end
      @(negedge clk) clr_n = 1'b1;
      @(posedge clk) #1;
      bus.wr_en = 1'b1;
      bus.data_in = 16'hABCD;
      @(posedge clk) #1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b1;
      @(posedge clk) #1;
      bus.rd_en = 1'b0;
      checks++; if (bus.data_valid !== 1'b1 || bus.data_out !== 16'hABCD) begin errors++; $display("FAIL mid_first_word got v=%b %h exp 1/abcd", bus.data_valid, bus.data_out); end
      checks++; if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin errors++; $display("FAIL mid_end got empty=%b count=%0d exp 1/0", bus.empty, bus.count); end
   endtask
   initial begin
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.data_in = '0;
      test_reset();
      test_underflow();
      test_fill();
      test_drain();
      test_wrap();
      test_back_to_back();
      test_simul_edges();
      test_midreset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
